exercicio1: RTL and testbench

Four-input NAND gate (f = ~(a & b & c & d)) with a registered copy of the result and an optional truth-table coverage tracker. The combinational output drives downstream logic with zero latency. The clocked side gives lab and self-check logic a sampled result, a record of which of the 16 input combinations have been applied, and a count of cycles where the output was low.

---
 rtl/exercicio1_pkg.sv | 17 +
 rtl/exercicio1_cov.sv | 47 ++++
 rtl/exercicio1.sv | 58 +++++
 tb/tb_exercicio1.sv | 120 ++++++++++++
 4 files changed

// File: rtl/exercicio1_pkg.sv
// Shared constants and helpers for the four-input NAND with coverage tracking.
package exercicio1_pkg;

  localparam int NUM_INPUTS = 4;
  localparam int NUM_COMBOS = 16;

  // a is the MSB and d the LSB of the truth-table row index.
  function automatic logic [NUM_INPUTS-1:0] combo_idx(
    input logic a,
    input logic b,
    input logic c,
    input logic d
  );
    return {a, b, c, d};
  endfunction

endpackage

// File: rtl/exercicio1_cov.sv
// Truth-table coverage tracker: sticky seen bitmap, all-seen flag and a
// saturating count of sampled cycles where the NAND output was low.
module exercicio1_cov
  import exercicio1_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] idx,
  input  logic                  f,
  output logic [NUM_COMBOS-1:0] seen,
  output logic                  all_seen,
  output logic [COUNT_W-1:0]    low_count
);

  logic [NUM_COMBOS-1:0] seen_reg;
  logic [NUM_COMBOS-1:0] seen_next;
  logic                  all_seen_reg;
  logic [COUNT_W-1:0]    low_count_reg;

  always_comb begin
    seen_next      = seen_reg;
    seen_next[idx] = 1'b1;
  end

  // all_seen is derived from the next bitmap so it rises on the same edge
  // that fills the last hole.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_reg      <= '0;
      all_seen_reg  <= 1'b0;
      low_count_reg <= '0;
    end else begin
      seen_reg     <= seen_next;
      all_seen_reg <= &seen_next;
      if (!f && (low_count_reg != {COUNT_W{1'b1}})) begin
        low_count_reg <= low_count_reg + 1'b1;
      end
    end
  end

  assign seen      = seen_reg;
  assign all_seen  = all_seen_reg;
  assign low_count = low_count_reg;

endmodule

// File: rtl/exercicio1.sv
// Four-input NAND with a registered copy of the result. Define
// EXERCICIO1_COVERAGE_EN to build the truth-table coverage tracker.
module exercicio1
  import exercicio1_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a,
  input  logic                  b,
  input  logic                  c,
  input  logic                  d,
  output logic                  f,
  output logic                  f_q,
  output logic [NUM_COMBOS-1:0] seen,
  output logic                  all_seen,
  output logic [COUNT_W-1:0]    low_count
);

  logic f_q_reg;

  assign f = ~(a & b & c & d);

  // Reset value matches NAND(0,0,0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q_reg <= 1'b1;
    end else begin
      f_q_reg <= f;
    end
  end

  assign f_q = f_q_reg;

`ifdef EXERCICIO1_COVERAGE_EN
  logic [NUM_INPUTS-1:0] idx;

  assign idx = combo_idx(a, b, c, d);

  exercicio1_cov #(
    .COUNT_W (COUNT_W)
  ) u_cov (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .f         (f),
    .seen      (seen),
    .all_seen  (all_seen),
    .low_count (low_count)
  );
`else
  assign seen      = '0;
  assign all_seen  = 1'b0;
  assign low_count = '0;
`endif

endmodule

// File: tb/tb_exercicio1.sv
// Directed bench for exercicio1: combinational sweep plus a scoreboard of
// expected registered outputs, adapting to the EXERCICIO1_COVERAGE_EN build.
module tb_exercicio1;

  localparam int CW = 2;
`ifdef EXERCICIO1_COVERAGE_EN
  localparam bit COV = 1'b1;
`else
  localparam bit COV = 1'b0;
`endif

  typedef struct packed {
    logic          f_q;
    logic [15:0]   seen;
    logic          all_seen;
    logic [CW-1:0] low_count;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic          f, f_q, all_seen;
  logic [15:0]   seen;
  logic [CW-1:0] low_count;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  logic          m_fq = 1'b1;
  logic [15:0]   m_seen = '0;
  logic [CW-1:0] m_low = '0;

  always #5 clk = ~clk;

  exercicio1 #(.COUNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .f         (f),
    .f_q       (f_q),
    .seen      (seen),
    .all_seen  (all_seen),
    .low_count (low_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clocked transaction: drive at negedge, push expectation, compare after edge.
  task automatic step(input string tag, input logic [3:0] v, input logic r);
    exp_t e;
    @(negedge clk);
    {a, b, c, d} = v;
    rst = r;
    #1;
    check({tag, "/f"}, {15'd0, f}, {15'd0, ~&v});
    if (r) begin
      m_fq = 1'b1; m_seen = '0; m_low = '0;
    end else begin
      m_fq = ~&v;
      m_seen[v] = 1'b1;
      if (v == 4'hF && m_low != {CW{1'b1}}) m_low = m_low + 1'b1;
    end
    e.f_q       = m_fq;
    e.seen      = COV ? m_seen : 16'h0;
    e.all_seen  = COV ? (m_seen == 16'hFFFF) : 1'b0;
    e.low_count = COV ? m_low : '0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    $display("step %s in=%b rst=%b f_q=%b seen=%h all=%b low=%0d", tag, v, r,
             f_q, seen, all_seen, low_count);
    check({tag, "/f_q"},       {15'd0, f_q},      {15'd0, e.f_q});
    check({tag, "/seen"},      seen,              e.seen);
    check({tag, "/all_seen"},  {15'd0, all_seen}, {15'd0, e.all_seen});
    check({tag, "/low_count"}, {14'd0, low_count}, {14'd0, e.low_count});
  endtask

  initial begin
    logic [3:0] part [16];
    // Combinational sweep
    for (int i = 0; i < 16; i++) begin
      {a, b, c, d} = i[3:0];
      #10;
      check($sformatf("sweep%0d", i), {15'd0, f}, {15'd0, (i != 15)});
    end
    // Reset, arbitrary activity, reset again
    step("rst0", 4'h0, 1'b1);
    step("act0", 4'hF, 1'b0);
    step("act1", 4'h5, 1'b0);
    step("rst1", 4'hF, 1'b1);
    step("rst2", 4'h3, 1'b1);
    // Partial coverage skipping 1000, 0010 twice
    part = '{4'h0, 4'h1, 4'h2, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
             4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int i = 0; i < 16; i++) step($sformatf("part%0d", i), part[i], 1'b0);
    if (COV) check("partial_seen", seen, 16'hFEFF);
    step("last", 4'h8, 1'b0);
    check("full_all_seen", {15'd0, all_seen}, {15'd0, COV});
    // Saturation from reset
    step("rst3", 4'h0, 1'b1);
    for (int i = 0; i < 5; i++) step($sformatf("sat%0d", i), 4'hF, 1'b0);
    // Reset on the edge where 1111 is applied
    step("midrst", 4'hF, 1'b1);
    step("post", 4'h6, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
